// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared frame geometry, FSM encoding and byte swap for the SPI RAM link
package spi_ram_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int WORD_COUNT  = 64 * 96;
  localparam int WORD_ADDR_W = $clog2(WORD_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Low byte goes on the wire first; the slave applies the same swap on receive.
  function automatic logic [WORD_WIDTH-1:0] byte_swap(input logic [WORD_WIDTH-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/spi_sck_div.sv
// rtl/spi_sck_div.sv - sck half-period divider with enable, clear and edge tick outputs
module spi_sck_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       tick;

  assign tick = en_i && (cnt_q == 8'd0);

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clr_i) begin
      cnt_d = RELOAD;
      sck_d = 1'b0;
    end else if (en_i) begin
      if (tick) begin
        cnt_d = RELOAD;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign rise_tick_o = tick & ~sck_q;
  assign fall_tick_o = tick & sck_q;

endmodule

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI mode-0 transmit master streaming a RAM frame of 16-bit words
// Optional SPI_RAM_MASTER_PREFETCH_EN reads the next word during the current one for a uniform sck.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned WORDS   = WORD_COUNT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic                   ram_rd,
  input  logic [WORD_WIDTH-1:0]  ram_data,
  output logic                   sck,
  output logic                   cs,
  output logic                   mosi
);

  localparam logic [WORD_ADDR_W-1:0] LAST      = WORD_ADDR_W'(WORDS - 1);
  localparam logic [15:0]            HOLD_LOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0]            GAP_LOAD  = 16'(CS_GAP - 1);

  state_t                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [3:0]             bit_q, bit_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   cs_q, cs_d;
  logic                   done_q, done_d;
  logic                   rise_tick, fall_tick;

`ifdef SPI_RAM_MASTER_PREFETCH_EN
  logic                  pf_rd_q, pf_rd_d;
  logic                  pf_cap_q, pf_cap_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
`else
  logic unused_rise;
  assign unused_rise = rise_tick;
`endif

  spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == SHIFT),
    .clr_i       (state_q != SHIFT),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
`ifdef SPI_RAM_MASTER_PREFETCH_EN
    pf_rd_d  = 1'b0;
    pf_cap_d = pf_rd_q;
    hold_d   = pf_cap_q ? ram_data : hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = byte_swap(ram_data);
        bit_d   = 4'd15;
        cs_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
`ifdef SPI_RAM_MASTER_PREFETCH_EN
        if (rise_tick && (bit_q == 4'd15) && (addr_q != LAST)) pf_rd_d = 1'b1;
`endif
        // Data only moves on the falling edge; the slave samples on the rising one.
        if (fall_tick) begin
          if (bit_q != 4'd0) begin
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q - 4'd1;
          end else if (addr_q == LAST) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            addr_d = addr_q + WORD_ADDR_W'(1);
`ifdef SPI_RAM_MASTER_PREFETCH_EN
            shift_d = byte_swap(hold_q);
            bit_d   = 4'd15;
`else
            state_d = FETCH;
`endif
          end
        end
      end
      HOLD: begin
        if (cnt_q == 16'd0) begin
          cs_d    = 1'b1;
          cnt_d   = GAP_LOAD;
          shift_d = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      cs_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef SPI_RAM_MASTER_PREFETCH_EN
      pf_rd_q  <= 1'b0;
      pf_cap_q <= 1'b0;
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      done_q   <= done_d;
`ifdef SPI_RAM_MASTER_PREFETCH_EN
      pf_rd_q  <= pf_rd_d;
      pf_cap_q <= pf_cap_d;
      hold_q   <= hold_d;
`endif
    end
  end

`ifdef SPI_RAM_MASTER_PREFETCH_EN
  assign ram_rd   = (state_q == FETCH) | pf_rd_q;
  assign ram_addr = pf_rd_q ? (addr_q + WORD_ADDR_W'(1)) : addr_q;
`else
  assign ram_rd   = (state_q == FETCH);
  assign ram_addr = addr_q;
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign cs   = cs_q;
  assign mosi = shift_q[15];

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - directed self-checking bench for spi_ram_master with a slave-side model
module tb_spi_ram_master;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
  localparam int WORDS   = 40;
`ifdef SPI_RAM_MASTER_PREFETCH_EN
  localparam int EXP_LONG = 0;
`else
  localparam int EXP_LONG = WORDS - 1;
`endif
  localparam int EXP_NORM = 16 * WORDS - 1 - EXP_LONG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, ram_rd, sck, cs, mosi;
  logic [12:0] ram_addr;
  logic [15:0] ram_data = 16'h0000;

  logic [15:0] mem       [0:WORDS-1];
  logic [15:0] slave_mem [0:WORDS-1];

  int errors = 0;
  int checks = 0;

  int cyc = 0, rd_count = 0, done_count = 0, done_cyc = 0;
  int busy_fall_count = 0, busy_fall_cyc = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, cs_rise_count = 0;
  int rise_count = 0, rise_cyc = 0, fall_cyc = 0;
  int cs_to_rise = 0, n_lo_norm = 0, n_lo_long = 0, n_lo_other = 0, n_hi_bad = 0;
  int s_bits = 0, s_addr = 0, wr_count = 0;
  logic [15:0] shreg = 16'h0000, first_raw = 16'h0000;
  logic prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0, first_pending = 1'b0;

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_rd   (ram_rd),
    .ram_data (ram_data),
    .sck      (sck),
    .cs       (cs),
    .mosi     (mosi)
  );

  always @(posedge clk) begin
    if (ram_rd) ram_data <= (int'(ram_addr) < WORDS) ? mem[int'(ram_addr)] : 16'hDEAD;
  end

  // Slave-side observer: samples mosi on sck rise and rebuilds words (first byte = low byte).
  always @(negedge clk) begin
    cyc++;
    if (ram_rd) rd_count++;
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy) begin
      busy_fall_count++;
      busy_fall_cyc = cyc;
    end
    if (prev_cs && !cs) begin
      cs_fall_cyc   = cyc;
      first_pending = 1'b1;
    end
    if (!prev_cs && cs) begin
      cs_rise_count++;
      cs_rise_cyc = cyc;
      s_bits = 0;
      s_addr = 0;
    end
    if (!prev_sck && sck) begin
      rise_count++;
      if (first_pending) begin
        cs_to_rise    = cyc - cs_fall_cyc;
        first_pending = 1'b0;
      end else if (cyc - fall_cyc == CLK_DIV) n_lo_norm++;
      else if (cyc - fall_cyc == CLK_DIV + 2) n_lo_long++;
      else n_lo_other++;
      rise_cyc = cyc;
      if (!cs) begin
        shreg = {shreg[14:0], mosi};
        s_bits++;
        if (s_bits == 16) begin
          if (s_addr == 0) first_raw = shreg;
          if (s_addr < WORDS) slave_mem[s_addr] = {shreg[7:0], shreg[15:8]};
          s_addr++;
          wr_count++;
          s_bits = 0;
        end
      end
    end
    if (prev_sck && !sck) begin
      if (cyc - rise_cyc != CLK_DIV) n_hi_bad++;
      fall_cyc = cyc;
    end
    prev_cs   = cs;
    prev_sck  = sck;
    prev_busy = busy;
  end

  task automatic mon_clear();
    rd_count = 0; done_count = 0; busy_fall_count = 0; cs_rise_count = 0;
    rise_count = 0; wr_count = 0; n_lo_norm = 0; n_lo_long = 0; n_lo_other = 0;
    n_hi_bad = 0; first_raw = 16'h0000; cs_to_rise = 0;
    for (int i = 0; i < WORDS; i++) slave_mem[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_count != 0) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int slave_mismatches();
    int n = 0;
    for (int i = 0; i < WORDS; i++) if (slave_mem[i] !== mem[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cs !== 1'b1)   begin errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
    checks++; if (sck !== 1'b0)  begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd: got %b expected 0", ram_rd); end
    checks++; if (ram_addr !== 13'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
    rst = 1'b0;
  endtask

  task automatic test_frame();
    mem[0] = 16'h1234;
    for (int i = 1; i < WORDS; i++) mem[i] = 16'($urandom);
    mon_clear();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_after_start: got %b expected 1", busy); end
    wait_done(5000, "frame");
    checks++; if (first_raw !== 16'h3412) begin errors++; $display("FAIL frame_first_bits: got %h expected 3412", first_raw); end
    checks++; if (rise_count != 16 * WORDS) begin errors++; $display("FAIL frame_rises: got %0d expected %0d", rise_count, 16 * WORDS); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_count); end
    checks++; if (cs_rise_count != 1) begin errors++; $display("FAIL frame_cs_rises: got %0d expected 1", cs_rise_count); end
    checks++; if (slave_mismatches() != 0) begin errors++; $display("FAIL frame_slave_ram: got %0d bad words expected 0", slave_mismatches()); end
    checks++; if (wr_count != WORDS) begin errors++; $display("FAIL frame_slave_writes: got %0d expected %0d", wr_count, WORDS); end
    checks++; if (rd_count != WORDS) begin errors++; $display("FAIL frame_ram_reads: got %0d expected %0d", rd_count, WORDS); end
    checks++; if (n_hi_bad != 0) begin errors++; $display("FAIL frame_high_phase: got %0d bad expected 0", n_hi_bad); end
    checks++; if (n_lo_norm != EXP_NORM) begin errors++; $display("FAIL frame_low_norm: got %0d expected %0d", n_lo_norm, EXP_NORM); end
    checks++; if (n_lo_long != EXP_LONG) begin errors++; $display("FAIL frame_low_boundary: got %0d expected %0d", n_lo_long, EXP_LONG); end
    checks++; if (n_lo_other != 0) begin errors++; $display("FAIL frame_low_other: got %0d expected 0", n_lo_other); end
    checks++; if (cs_to_rise != CLK_DIV) begin errors++; $display("FAIL frame_cs_setup: got %0d expected %0d", cs_to_rise, CLK_DIV); end
    checks++; if (cs_rise_cyc - fall_cyc != CLK_DIV) begin errors++; $display("FAIL frame_cs_hold: got %0d expected %0d", cs_rise_cyc - fall_cyc, CLK_DIV); end
    checks++; if (done_cyc - cs_rise_cyc != CS_GAP) begin errors++; $display("FAIL frame_gap: got %0d expected %0d", done_cyc - cs_rise_cyc, CS_GAP); end
    checks++; if (busy_fall_cyc != done_cyc) begin errors++; $display("FAIL frame_busy_end: got %0d expected %0d", busy_fall_cyc, done_cyc); end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < WORDS; i++) mem[i] = 16'(i * 16'h0101 + 16'h5A0F);
    mon_clear();
    pulse_start();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(5000, "restart");
    checks++; if (rise_count != 16 * WORDS) begin errors++; $display("FAIL restart_rises: got %0d expected %0d", rise_count, 16 * WORDS); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_count); end
    checks++; if (busy_fall_count != 1 || busy_fall_cyc != done_cyc) begin errors++; $display("FAIL restart_busy: got falls=%0d at %0d expected 1 at %0d", busy_fall_count, busy_fall_cyc, done_cyc); end
    checks++; if (slave_mismatches() != 0) begin errors++; $display("FAIL restart_slave_ram: got %0d bad words expected 0", slave_mismatches()); end
  endtask

  task automatic test_reset_mid_frame();
    bit hit = 1'b0;
    mon_clear();
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (wr_count == 37 && s_bits == 6) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach: got words=%0d expected 37", wr_count); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs !== 1'b1)   begin errors++; $display("FAIL midrst_cs: got %b expected 1", cs); end
    checks++; if (sck !== 1'b0)  begin errors++; $display("FAIL midrst_sck: got %b expected 0", sck); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL midrst_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (ram_addr !== 13'd0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", ram_addr); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_count != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_count); end
    mem[0] = 16'hA5C3;
    mon_clear();
    pulse_start();
    wait_done(5000, "after_rst");
    checks++; if (first_raw !== 16'hC3A5) begin errors++; $display("FAIL after_rst_first_bits: got %h expected c3a5", first_raw); end
    checks++; if (wr_count != WORDS) begin errors++; $display("FAIL after_rst_writes: got %0d expected %0d", wr_count, WORDS); end
    checks++; if (slave_mismatches() != 0) begin errors++; $display("FAIL after_rst_slave_ram: got %0d bad words expected 0", slave_mismatches()); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]       = 16'h0000;
      slave_mem[i] = 16'h0000;
    end
    test_reset();
    test_frame();
    test_restart_ignored();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
SPI transmit-only master that streams a RAM-resident frame of 16-bit words out over SPI mode 0. It is the sending end of the framebuffer link: it reads WORD_COUNT words from a synchronous-read RAM port and serialises them. Byte order and bit order match the FPGA-side SPI RAM slave, so word N of this RAM lands at address N of the slave's RAM unchanged. It sits between the frame RAM and the SPI pins, and is kicked once per frame by a start pulse.

Parameters:
CLK_DIV, 4, sck half-period in clk cycles; legal range 2..255; the receiver needs >= 3 for its 3-stage sampler.
CS_GAP, 4, clk cycles cs is held high after a frame before the block returns to IDLE.

Ports:
clk  in  1  system clock; all logic on posedge clk.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a frame when idle.
busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
done  out  1  one-cycle pulse when the frame is complete and cs is high again.
ram_addr  out  13  RAM read address (WORD_ADDR_W).
ram_rd  out  1  read enable; data is valid on ram_data the cycle after ram_rd.
ram_data  in  16  RAM read data.
sck  out  1  SPI clock; idles low.
cs  out  1  chip select, active low; idles high.
mosi  out  1  serial data; idles low.

Behaviour:
- Reset values: cs=1, sck=0, mosi=0, busy=0, done=0, ram_rd=0, ram_addr=0, state=IDLE. Reset mid-frame aborts on the next edge with no done pulse.
- Clock naming is fixed: single clock clk; reset rst is synchronous and active-high.
- States: IDLE, FETCH, LOAD, SHIFT, HOLD, GAP.
- IDLE: start=1 -> FETCH, addr=0, busy=1. start in any other state is ignored.
- FETCH: ram_rd=1 for one cycle at the current addr -> LOAD.
- LOAD: cs=0; the shifter captures ram_data byte-swapped as {ram_data[7:0], ram_data[15:8]}; mosi = shifter MSB. Set bit counter=15 and half-period counter=CLK_DIV-1 -> SHIFT.
- SHIFT: the half-period counter decrements each clk. At 0, sck toggles and the counter reloads CLK_DIV-1.
  - Rising edge: mosi is held, so the slave samples it there.
  - Falling edge with bits remaining: shift left, mosi = new MSB, bit counter decrements.
  - Falling edge after bit 0: if addr == WORD_COUNT-1 -> HOLD; else addr+1 -> FETCH.
- Bit order: first byte on the wire is ram_data[7:0] MSB first, then ram_data[15:8] MSB first.
- HOLD: cs stays 0 and sck stays 0 for CLK_DIV cycles, then cs=1 -> GAP.
- GAP: counts CS_GAP cycles with cs=1, then done=1 for one cycle, busy=0 -> IDLE.
- sck is low whenever it is not in SHIFT. The first rising edge comes CLK_DIV cycles after cs falls (cs setup time = one half-period).
- Without prefetch, there is an inter-word gap of 2 clk cycles (FETCH, LOAD) plus the low half-period. The slave is edge-driven and tolerates this gap.
- Address arithmetic is 13-bit. Terminal count is checked before the increment, so the address never wraps.

Optional Feature:
SPI_RAM_MASTER_PREFETCH_EN
- Defined:
  - The next word is read during the current word's first high half-period into a 16-bit holding register.
  - At the falling edge after bit 0, the shifter loads directly from the holding register.
  - FETCH and LOAD are used only for word 0, so sck runs at a uniform period across the whole frame.
  - No read is issued after the last word.
- Undefined: behaviour is as described under Behaviour, with the 2-cycle inter-word gap.

Decomposition:
- Shared package spi_ram_pkg:
  - WORD_WIDTH=16, WORD_COUNT=64*96=6144, WORD_ADDR_W=$clog2(WORD_COUNT)=13.
  - State enum typedef.
  - Byte-swap function, shared with the slave.
- One sub-module: spi_sck_div.
  - Half-period counter with enable.
  - Outputs rise_tick/fall_tick pulses.
  - Reset and enable are driven by the FSM.

Test Plan:
- ram[0]=16'h1234, full frame -> first 16 mosi bits sampled on sck rising = 0x34 then 0x12; cs low throughout; 98304 rising edges total; exactly one done pulse.
- Loopback into the slave model with a random RAM image -> the slave's RAM equals the source RAM in all 6144 words; the slave sees ram_wr 6144 times.
- start pulsed again 100 cycles into a frame -> ignored; edge count is still 98304; busy never drops early.
- rst asserted mid-word (word 37, bit 9) -> next cycle cs=1, sck=0, mosi=0, busy=0, no done; a following start sends from address 0.
- CLK_DIV=2 -> sck high and low each exactly 2 clk; cs fall to first sck rise = 2 clk; last sck fall to cs rise = 2 clk; done exactly CS_GAP cycles after cs rises.
- With SPI_RAM_MASTER_PREFETCH_EN -> every sck period = 2*CLK_DIV including word boundaries, and ram_rd is asserted 6144 times; without it -> boundary low phase = CLK_DIV+2 cycles.
